matrix_ctrl_fsm: RTL and testbench

Parametrised top-level control FSM for the matrix calculator, successor to the fixed 100 MHz controller. It sits between the board I/O (switches, raw keys) and the input, generate, display, operation and UART-TX datapaths. New relative to the previous generation:
- internal key conditioning
- per-operation operand counting
- run watchdog
- error codes
- error return to the originating state
- runtime-configurable countdown

---
 rtl/matrix_ctrl_pkg.sv | 51 +++++
 rtl/matrix_ctrl_fsm_key_pulse.sv | 61 ++++++
 rtl/matrix_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_matrix_ctrl_fsm.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_ctrl_pkg.sv
// Shared definitions for the matrix calculator control FSM: state
// encoding, operation codes, error codes, mode values and the
// operand-count helper.
package matrix_ctrl_pkg;

  // State encoding, also driven out on state_o for observation.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_MENU       = 4'd1,
    S_INPUT      = 4'd2,
    S_GEN        = 4'd3,
    S_GEN_SHOW   = 4'd4,
    S_DISPLAY    = 4'd5,
    S_OP_SELECT  = 4'd6,
    S_OP_OPERAND = 4'd7,
    S_OP_RUN     = 4'd8,
    S_OP_RESULT  = 4'd9,
    S_ERROR      = 4'd10
  } state_t;

  // Operation codes carried on sw[4:2].
  localparam logic [2:0] OP_T = 3'b000;  // transpose
  localparam logic [2:0] OP_A = 3'b001;  // add
  localparam logic [2:0] OP_B = 3'b010;  // scalar multiply
  localparam logic [2:0] OP_C = 3'b011;  // matrix multiply
  localparam logic [2:0] OP_J = 3'b100;  // convolution

  // Error codes reported on err_code.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_EXT  = 2'd1;
  localparam logic [1:0] ERR_OPND = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Values reported on mode_sel.
  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_INPUT = 2'b01;
  localparam logic [1:0] MODE_GEN   = 2'b10;
  localparam logic [1:0] MODE_OTHER = 2'b11;

  // Unary operations need one operand matrix, the rest need two.
  function automatic logic [1:0] operands_required(input logic [2:0] op);
    logic [1:0] n;
    case (op)
      OP_T, OP_B:       n = 2'd1;
      OP_A, OP_C, OP_J: n = 2'd2;
      default:          n = 2'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/matrix_ctrl_fsm_key_pulse.sv
// Key conditioning for one raw active-low key: two-flop synchroniser,
// stability debounce over DEB_CYC cycles, and a press-edge detector that
// yields a single-cycle pulse per accepted press. Release is debounced
// the same way but produces no pulse. Press-to-pulse latency is
// 2 + DEB_CYC + 1 cycles.
module key_pulse #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] deb_cnt;

  // Bring the asynchronous key into the clock domain (pressed = 1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the accepted one
  // for DEB_CYC consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      stable  <= 1'b0;
    end else if (sync2 == stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CW'(DEB_CYC - 1)) begin
      deb_cnt <= '0;
      stable  <= sync2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Registered rising-edge detect on the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/matrix_ctrl_fsm.sv
// Top-level control FSM of the matrix calculator. Conditions the four
// board keys, steps through the menu/input/generate/display/operation
// flow, counts operands, guards OP_RUN with a watchdog and parks in ERROR
// with a configurable countdown before returning to where it came from.
//
// Pulse interface: operand_valid and done_flag are single-cycle
// qualifiers sampled on the clock edge they are high; start_input,
// start_gen, start_op and tx_start are single-cycle registered strobes
// that the datapaths must act on in the cycle they are seen, there is no
// back-pressure. error_flag and disp_en are levels.
module matrix_ctrl_fsm
  import matrix_ctrl_pkg::*;
#(
  parameter int TICK_CYC    = 100_000_000,
  parameter int DEB_CYC     = 1_000_000,
  parameter int RUN_TIMEOUT = 10_000_000,
  parameter int CD_W        = 8,
  parameter int CD_MIN      = 5,
  parameter int CD_MAX      = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      sw,
  input  logic [3:0]      key_n,
  input  logic [CD_W-1:0] cd_cfg,
  input  logic            operand_valid,
  input  logic            error_flag,
  input  logic            done_flag,
  output logic [3:0]      state_o,
  output logic [1:0]      mode_sel,
  output logic [2:0]      op_sel,
  output logic [CD_W-1:0] countdown_val,
  output logic [1:0]      err_code,
  output logic            start_input,
  output logic            start_gen,
  output logic            start_op,
  output logic            disp_en,
  output logic            tx_start
);

  localparam int TK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int WD_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  logic [3:0]      key_p;
  logic            ok_p;
  logic            back_p;
  logic            next_p;
  logic            menu_p;

  state_t          state;
  state_t          nxt;
  state_t          ret_state;
  logic [1:0]      nxt_err;
  logic [1:0]      mode_nxt;
  logic            entering;
  logic [1:0]      opnd_cnt;
  logic [1:0]      opnd_need;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;
  logic [TK_W-1:0] tick_cnt;
  logic [CD_W-1:0] cd_clamp;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_pulse #(.DEB_CYC(DEB_CYC)) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[i]),
      .pulse (key_p[i])
    );
  end

  assign ok_p      = key_p[0];
  assign back_p    = key_p[1];
  assign next_p    = key_p[2];
  assign menu_p    = key_p[3];

  assign state_o   = state;
  assign entering  = (nxt != state);
  assign opnd_need = operands_required(op_sel);
  assign wd_fire   = (wd_cnt == WD_W'(RUN_TIMEOUT - 1));

  // Requested countdown limited to the supported range.
  always_comb begin
    if (cd_cfg < CD_W'(CD_MIN))      cd_clamp = CD_W'(CD_MIN);
    else if (cd_cfg > CD_W'(CD_MAX)) cd_clamp = CD_W'(CD_MAX);
    else                             cd_clamp = cd_cfg;
  end

  // Next state: quick-menu beats external error beats ok/back/next.
  always_comb begin
    nxt     = state;
    nxt_err = ERR_NONE;
    if (state == S_IDLE) begin
      nxt = S_MENU;
    end else if (menu_p && state != S_MENU) begin
      nxt = S_MENU;
    end else if (error_flag && state != S_ERROR && state != S_OP_RESULT) begin
      nxt     = S_ERROR;
      nxt_err = ERR_EXT;
    end else begin
      case (state)
        S_MENU: begin
          if (ok_p) begin
            case (sw[1:0])
              2'b00:   nxt = S_INPUT;
              2'b01:   nxt = S_GEN;
              2'b10:   nxt = S_DISPLAY;
              default: nxt = S_OP_SELECT;
            endcase
          end
        end
        S_INPUT, S_DISPLAY: begin
          if (back_p) nxt = S_MENU;
        end
        S_GEN: begin
          if (done_flag)   nxt = S_GEN_SHOW;
          else if (back_p) nxt = S_MENU;
        end
        S_GEN_SHOW: begin
          if (ok_p)        nxt = S_GEN;
          else if (back_p) nxt = S_MENU;
        end
        S_OP_SELECT: begin
          if (ok_p)        nxt = S_OP_OPERAND;
          else if (back_p) nxt = S_MENU;
        end
        S_OP_OPERAND: begin
          if (ok_p) begin
            if (opnd_cnt >= opnd_need) begin
              nxt = S_OP_RUN;
            end else begin
              nxt     = S_ERROR;
              nxt_err = ERR_OPND;
            end
          end else if (back_p) begin
            nxt = S_OP_SELECT;
          end
        end
        S_OP_RUN: begin
          // A completion in the watchdog's last cycle still counts.
          if (done_flag) begin
            nxt = S_OP_RESULT;
          end else if (wd_fire) begin
            nxt     = S_ERROR;
            nxt_err = ERR_TMO;
          end
        end
        S_OP_RESULT: begin
          if (ok_p)        nxt = S_OP_OPERAND;
          else if (back_p) nxt = S_MENU;
          else if (next_p) nxt = S_OP_SELECT;
        end
        S_ERROR: begin
          if (countdown_val == '0 || back_p) nxt = ret_state;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Mode indication for the state being entered.
  always_comb begin
    case (nxt)
      S_IDLE, S_MENU, S_ERROR: mode_nxt = MODE_NONE;
      S_INPUT:                 mode_nxt = MODE_INPUT;
      S_GEN, S_GEN_SHOW:       mode_nxt = MODE_GEN;
      default:                 mode_nxt = MODE_OTHER;
    endcase
  end

  // State register plus every registered output and internal counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ret_state     <= S_IDLE;
      mode_sel      <= MODE_NONE;
      op_sel        <= '0;
      countdown_val <= '0;
      err_code      <= ERR_NONE;
      start_input   <= 1'b0;
      start_gen     <= 1'b0;
      start_op      <= 1'b0;
      disp_en       <= 1'b0;
      tx_start      <= 1'b0;
      opnd_cnt      <= '0;
      wd_cnt        <= '0;
      tick_cnt      <= '0;
    end else begin
      state       <= nxt;
      mode_sel    <= mode_nxt;
      start_input <= entering && (nxt == S_INPUT);
      start_gen   <= entering && (nxt == S_GEN);
      start_op    <= entering && (nxt == S_OP_RUN);
      disp_en     <= (nxt == S_GEN_SHOW) || (nxt == S_DISPLAY) ||
                     (nxt == S_OP_RESULT);
      tx_start    <= (entering && ((nxt == S_GEN_SHOW) || (nxt == S_DISPLAY) ||
                                   (nxt == S_OP_RESULT))) ||
                     (state == S_DISPLAY && nxt == S_DISPLAY && next_p);

      if (state == S_OP_SELECT && nxt == S_OP_OPERAND) op_sel <= sw[4:2];

      // Operand counter saturates at two and restarts on each entry.
      if (entering && nxt == S_OP_OPERAND) begin
        opnd_cnt <= '0;
      end else if (state == S_OP_OPERAND && operand_valid && opnd_cnt != 2'd2) begin
        opnd_cnt <= opnd_cnt + 1'b1;
      end

      // Watchdog counts cycles spent in OP_RUN.
      if (entering && nxt == S_OP_RUN) begin
        wd_cnt <= '0;
      end else if (state == S_OP_RUN && !wd_fire) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      // Error bookkeeping: capture code, countdown and return target on
      // entry, tick the countdown while parked, clear everything on exit.
      if (entering && nxt == S_ERROR) begin
        err_code      <= nxt_err;
        countdown_val <= cd_clamp;
        tick_cnt      <= '0;
        ret_state     <= (state == S_OP_RUN || state == S_OP_OPERAND) ?
                         S_OP_OPERAND : state;
      end else if (state == S_ERROR && nxt != S_ERROR) begin
        err_code      <= ERR_NONE;
        countdown_val <= '0;
        tick_cnt      <= '0;
      end else if (state == S_ERROR) begin
        if (tick_cnt == TK_W'(TICK_CYC - 1)) begin
          tick_cnt <= '0;
          if (countdown_val != '0) countdown_val <= countdown_val - 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_ctrl_fsm.sv
// Directed bench for matrix_ctrl_fsm. Stimulus pushes the expected
// state-change / strobe event (with the cycle it must appear on) into a
// queue; a monitor pops and compares whenever the DUT shows one.
`timescale 1ns/1ps
module tb_matrix_ctrl_fsm;
  import matrix_ctrl_pkg::*;

  localparam int TICK_CYC    = 20;
  localparam int DEB_CYC     = 4;
  localparam int RUN_TIMEOUT = 50;
  localparam int CD_W        = 8;
  localparam int EW          = 21;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      sw;
  logic [3:0]      key_n;
  logic [CD_W-1:0] cd_cfg;
  logic            operand_valid;
  logic            error_flag;
  logic            done_flag;
  logic [3:0]      state_o;
  logic [1:0]      mode_sel;
  logic [2:0]      op_sel;
  logic [CD_W-1:0] countdown_val;
  logic [1:0]      err_code;
  logic            start_input;
  logic            start_gen;
  logic            start_op;
  logic            disp_en;
  logic            tx_start;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int ok_cnt      = 0;
  int ok_last     = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [3:0]    prev_state = 4'd0;

  matrix_ctrl_fsm #(
    .TICK_CYC    (TICK_CYC),
    .DEB_CYC     (DEB_CYC),
    .RUN_TIMEOUT (RUN_TIMEOUT),
    .CD_W        (CD_W),
    .CD_MIN      (5),
    .CD_MAX      (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .key_n         (key_n),
    .cd_cfg        (cd_cfg),
    .operand_valid (operand_valid),
    .error_flag    (error_flag),
    .done_flag     (done_flag),
    .state_o       (state_o),
    .mode_sel      (mode_sel),
    .op_sel        (op_sel),
    .countdown_val (countdown_val),
    .err_code      (err_code),
    .start_input   (start_input),
    .start_gen     (start_gen),
    .start_op      (start_op),
    .disp_en       (disp_en),
    .tx_start      (tx_start)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] pack(input logic [3:0] st, input logic [1:0] md,
                                         input logic [1:0] ec, input logic de,
                                         input logic tx, input logic si, input logic sg,
                                         input logic so, input logic [7:0] cd);
    return {st, md, ec, de, tx, si, sg, so, cd};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ev(input logic [3:0] st, input logic [1:0] md, input logic [1:0] ec,
                        input logic de, input logic tx, input logic si, input logic sg,
                        input logic so, input logic [7:0] cd, input int at);
    exp_q.push_back(pack(st, md, ec, de, tx, si, sg, so, cd));
    exp_cyc_q.push_back(at);
  endtask

  task automatic key_down(input int idx, output int p);
    step();
    key_n[idx] = 1'b0;
    p = cyc;
  endtask

  task automatic key_release(input int idx, input int len);
    repeat (len) step();
    key_n[idx] = 1'b1;
    repeat (10) step();
  endtask

  task automatic pulse_ov();
    step();
    operand_valid = 1'b1;
    step();
    operand_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, %0d expected events never seen", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp_v;
    logic [EW-1:0] msk;
    int            ec;
    if (rst) begin
      prev_state = state_o;
    end else begin
      act = pack(state_o, mode_sel, err_code, disp_en, tx_start, start_input,
                 start_gen, start_op, countdown_val);
      if (state_o != prev_state || tx_start || start_input || start_gen || start_op) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got %h at cycle %0d, expected no event", act, cyc);
        end else begin
          exp_v = exp_q.pop_front();
          ec    = exp_cyc_q.pop_front();
          msk   = (exp_v[20:17] == S_ERROR) ? {EW{1'b1}} : {{(EW-8){1'b1}}, 8'h00};
          if (((act ^ exp_v) & msk) != '0 || cyc != ec) begin
            miscompares++;
            $display("FAIL event_st%0d: got %h at cycle %0d, expected %h at cycle %0d",
                     exp_v[20:17], act, cyc, exp_v, ec);
          end
        end
      end
      prev_state = state_o;
      if (dut.ok_p) begin
        ok_cnt++;
        ok_last = cyc;
      end
    end
  end

  // Global time bound
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int p;
    int d;
    int ok0;
    rst = 1'b1; sw = '0; key_n = 4'hF; cd_cfg = '0;
    operand_valid = 1'b0; error_flag = 1'b0; done_flag = 1'b0;
    repeat (3) step();
    check("reset_outputs", {8'h0, state_o, mode_sel, op_sel, countdown_val, err_code,
                            start_input, start_gen, start_op, disp_en, tx_start}, 32'h0);

    // IDLE -> MENU one cycle after reset release
    rst = 1'b0;
    p = cyc;
    exp_ev(S_MENU, 2'b00, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 1);
    wait_drain("menu_after_reset");

    // 10-cycle ok press in MENU with mode GEN
    sw  = 5'b00001;
    ok0 = ok_cnt;
    key_down(0, p);
    exp_ev(S_GEN, 2'b10, ERR_NONE, 0, 0, 0, 1, 0, 8'd0, p + 8);
    key_release(0, 10);
    wait_drain("menu_to_gen");
    check("ok_single_pulse", ok_cnt - ok0, 1);
    check("ok_pulse_latency", ok_last - p, 7);

    // done_flag -> GEN_SHOW
    step(); done_flag = 1'b1; d = cyc;
    exp_ev(S_GEN_SHOW, 2'b10, ERR_NONE, 1, 1, 0, 0, 0, 8'd0, d + 1);
    step(); done_flag = 1'b0;
    wait_drain("gen_to_show");

    // 3-cycle glitch: no pulse, no transition
    ok0 = ok_cnt;
    key_down(0, p);
    key_release(0, 3);
    repeat (5) step();
    check("glitch_no_pulse", ok_cnt - ok0, 0);

    // back -> MENU
    key_down(1, p);
    exp_ev(S_MENU, 2'b00, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(1, 6);
    wait_drain("show_back_menu");

    // Operation path with matrix multiply (two operands needed)
    sw = {OP_C, 2'b11};
    key_down(0, p);
    exp_ev(S_OP_SELECT, 2'b11, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(0, 6);
    wait_drain("menu_to_opsel");
    key_down(0, p);
    exp_ev(S_OP_OPERAND, 2'b11, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(0, 6);
    wait_drain("opsel_to_operand");
    check("op_sel_latch", op_sel, OP_C);

    // One operand only: shortfall error, countdown 5 s, auto return
    pulse_ov();
    cd_cfg = 8'd3;
    key_down(0, p);
    exp_ev(S_ERROR, 2'b00, ERR_OPND, 0, 0, 0, 0, 0, 8'd5, p + 8);
    exp_ev(S_OP_OPERAND, 2'b11, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8 + 101);
    key_release(0, 6);
    wait_drain("operand_shortfall");

    // Two operands: run, then watchdog timeout, then back
    pulse_ov();
    pulse_ov();
    key_down(0, p);
    exp_ev(S_OP_RUN, 2'b11, ERR_NONE, 0, 0, 0, 0, 1, 8'd0, p + 8);
    exp_ev(S_ERROR, 2'b00, ERR_TMO, 0, 0, 0, 0, 0, 8'd5, p + 8 + RUN_TIMEOUT);
    key_release(0, 6);
    wait_drain("run_watchdog");
    key_down(1, p);
    exp_ev(S_OP_OPERAND, 2'b11, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(1, 6);
    wait_drain("error_back");

    // Quick-menu, then DISPLAY with a next press
    key_down(3, p);
    exp_ev(S_MENU, 2'b00, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(3, 6);
    wait_drain("quick_menu");
    sw = 5'b00010;
    key_down(0, p);
    exp_ev(S_DISPLAY, 2'b11, ERR_NONE, 1, 1, 0, 0, 0, 8'd0, p + 8);
    key_release(0, 6);
    wait_drain("menu_to_display");
    key_down(2, p);
    exp_ev(S_DISPLAY, 2'b11, ERR_NONE, 1, 1, 0, 0, 0, 8'd0, p + 8);
    key_release(2, 6);
    wait_drain("display_next_tx");

    // External error in DISPLAY, countdown clamped to 15, back returns
    cd_cfg = 8'd20;
    step(); error_flag = 1'b1; d = cyc;
    exp_ev(S_ERROR, 2'b00, ERR_EXT, 0, 0, 0, 0, 0, 8'd15, d + 1);
    step(); error_flag = 1'b0;
    wait_drain("display_ext_error");
    key_down(1, p);
    exp_ev(S_DISPLAY, 2'b11, ERR_NONE, 1, 1, 0, 0, 0, 8'd0, p + 8);
    key_release(1, 6);
    wait_drain("error_return_display");

    // Transpose run to OP_RESULT
    key_down(3, p);
    exp_ev(S_MENU, 2'b00, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(3, 6);
    wait_drain("menu_again");
    sw = {OP_T, 2'b11};
    key_down(0, p);
    exp_ev(S_OP_SELECT, 2'b11, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(0, 6);
    wait_drain("opsel_t");
    key_down(0, p);
    exp_ev(S_OP_OPERAND, 2'b11, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    key_release(0, 6);
    wait_drain("operand_t");
    pulse_ov();
    key_down(0, p);
    exp_ev(S_OP_RUN, 2'b11, ERR_NONE, 0, 0, 0, 0, 1, 8'd0, p + 8);
    key_release(0, 6);
    wait_drain("run_t");
    step(); done_flag = 1'b1; d = cyc;
    exp_ev(S_OP_RESULT, 2'b11, ERR_NONE, 1, 1, 0, 0, 0, 8'd0, d + 1);
    step(); done_flag = 1'b0;
    wait_drain("run_done");

    // Quick-menu and error_flag in the same cycle from OP_RESULT
    key_down(3, p);
    exp_ev(S_MENU, 2'b00, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 8);
    repeat (7) step();
    error_flag = 1'b1;
    step();
    error_flag = 1'b0;
    key_release(3, 0);
    wait_drain("menu_beats_error");

    // Error from MENU, then reset while parked in ERROR
    step(); error_flag = 1'b1; d = cyc;
    exp_ev(S_ERROR, 2'b00, ERR_EXT, 0, 0, 0, 0, 0, 8'd15, d + 1);
    step(); error_flag = 1'b0;
    wait_drain("menu_ext_error");
    repeat (3) step();
    rst = 1'b1;
    step();
    check("reset_in_error", {8'h0, state_o, mode_sel, op_sel, countdown_val, err_code,
                             start_input, start_gen, start_op, disp_en, tx_start}, 32'h0);
    rst = 1'b0;
    p = cyc;
    exp_ev(S_MENU, 2'b00, ERR_NONE, 0, 0, 0, 0, 0, 8'd0, p + 1);
    wait_drain("menu_after_rst2");
    repeat (5) step();
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
